// File: rtl/bundle_unpack_pkg.sv
// Shared helpers for the bundle narrowing stage.
// Holds the lowest-set-bit search used by the lane priority encoder.
package bundle_unpack_pkg;

  localparam int unsigned MAX_LANES = 32;

  // Scan downward so the lowest set bit is the last one written.
  function automatic int unsigned lsb_idx(
    input logic [MAX_LANES-1:0] v
  );
    lsb_idx = 0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (v[i]) lsb_idx = unsigned'(i);
    end
  endfunction

endpackage

// File: rtl/bundle_unpack_prio.sv
// Lowest-set-bit priority encoder over an N-bit lane vector.
// Also reports whether any bit is set and whether exactly one is.
import bundle_unpack_pkg::*;

module prio_enc_low #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_any,
  output logic          o_one_hot
);

  logic [MAX_LANES-1:0] w_wide;

  assign w_wide    = MAX_LANES'(i_vec);
  assign o_idx     = IW'(lsb_idx(w_wide));
  assign o_any     = |i_vec;
  assign o_one_hot = o_any &&
    ((i_vec & (i_vec - N'(1))) == '0);

endmodule

// File: rtl/bundle_unpack.sv
// Serializes a masked N-lane bundle into one item per cycle.
// Lanes leave in ascending order; a last-item handshake admits the next bundle.
import bundle_unpack_pkg::*;

module bundle_unpack #(
  parameter type data_t = logic [31:0],
  parameter int  N      = 4,
  parameter int  IW     = $clog2(N)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  output logic            ready_in,
  input  logic            valid_in,
  input  data_t [N-1:0]   data_in,
  input  logic [N-1:0]    mask_in,
  input  logic            ready_out,
  output logic            valid_out,
  output data_t           data_out,
  output logic [IW-1:0]   lane_out,
  output logic            last_out
);

  data_t [N-1:0] r_buf;
  logic [N-1:0]  r_pend;

  logic [IW-1:0] w_sel;
  logic          w_any;
  logic          w_one;
  logic          w_fire_out;
  logic          w_fire_in;
  logic [N-1:0]  w_clr;

  prio_enc_low #(
    .N  (N),
    .IW (IW)
  ) u_enc (
    .i_vec     (r_pend),
    .o_idx     (w_sel),
    .o_any     (w_any),
    .o_one_hot (w_one)
  );

  assign valid_out  = w_any;
  assign data_out   = w_any ? r_buf[w_sel] : '0;
  assign lane_out   = w_any ? w_sel : '0;
  assign last_out   = w_any && w_one;

  assign w_fire_out = w_any && ready_out;
  assign ready_in   = resetn && !flush &&
    (!w_any || (w_fire_out && w_one));
  assign w_fire_in  = ready_in && valid_in;
  assign w_clr      = N'(1) << w_sel;

  // flush drops pending lanes but keeps buf contents
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pend <= '0;
      r_buf  <= '0;
    end else if (flush) begin
      r_pend <= '0;
    end else if (w_fire_in) begin
      r_buf  <= data_in;
      r_pend <= mask_in;
    end else if (w_fire_out) begin
      r_pend <= r_pend & ~w_clr;
    end
  end

endmodule

// File: tb/tb_bundle_unpack.sv
// Directed table-driven bench for bundle_unpack.
// Each record drives one cycle and lists the outputs expected that cycle.
module tb_bundle_unpack;

  logic              clk = 1'b0;
  logic              resetn;
  logic              flush;
  logic              ready_in;
  logic              valid_in;
  logic [3:0][31:0]  data_in;
  logic [3:0]        mask_in;
  logic              ready_out;
  logic              valid_out;
  logic [31:0]       data_out;
  logic [1:0]        lane_out;
  logic              last_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bundle_unpack #(
    .data_t (logic [31:0]),
    .N      (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .ready_in  (ready_in),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .mask_in   (mask_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .lane_out  (lane_out),
    .last_out  (last_out)
  );

  typedef struct {
    logic             rstn;
    logic             fl;
    logic             vin;
    logic [3:0][31:0] din;
    logic [3:0]       mask;
    logic             rdy;
    logic             vout;
    logic [31:0]      dout;
    logic [1:0]       lane;
    logic             last;
    logic             rin;
  } vec_t;

  vec_t tv[$];

  localparam logic [31:0] A = 32'hA0A0_0000;
  localparam logic [31:0] B = 32'hB0B0_0000;
  localparam logic [31:0] C = 32'hC0C0_0000;
  localparam logic [31:0] D = 32'hD0D0_0000;
  localparam logic [31:0] E = 32'hE0E0_0000;
  localparam logic [31:0] F = 32'hF0F0_0000;
  localparam logic [31:0] G = 32'h6060_0000;
  localparam logic [31:0] H = 32'h7070_0000;

  function automatic logic [3:0][31:0] mk(input logic [31:0] b);
    mk = {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic add(
    input logic rstn, input logic fl, input logic vin,
    input logic [31:0] base, input logic [3:0] mask,
    input logic rdy, input logic vout, input logic [31:0] dout,
    input logic [1:0] lane, input logic last, input logic rin
  );
    vec_t v;
    v.rstn = rstn; v.fl = fl; v.vin = vin;
    v.din = mk(base); v.mask = mask; v.rdy = rdy;
    v.vout = vout; v.dout = dout; v.lane = lane;
    v.last = last; v.rin = rin;
    tv.push_back(v);
  endtask

  task automatic chk(
    input string nm, input logic [31:0] act, input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic rstn, input logic fl, input logic vin,
    input logic [3:0][31:0] din, input logic [3:0] mask, input logic rdy
  );
    @(posedge clk);
    #1;
    resetn = rstn; flush = fl; valid_in = vin;
    data_in = din; mask_in = mask; ready_out = rdy;
    #1;
  endtask

  int n_items;
  int budget;

  initial begin
    resetn = 1'b0; flush = 1'b0; valid_in = 1'b0;
    data_in = '0; mask_in = '0; ready_out = 1'b0;
    repeat (2) @(posedge clk);

    // reset state, then 1011 bundle
    add(0,0,0, 0,4'b0000, 1, 0,0,      0,0,0);
    add(1,0,1, A,4'b1011, 1, 0,0,      0,0,1);
    add(1,0,0, 0,4'b0000, 1, 1,A+0,    0,0,0);
    add(1,0,0, 0,4'b0000, 1, 1,A+1,    1,0,0);
    add(1,0,0, 0,4'b0000, 1, 1,A+3,    3,1,1);
    add(1,0,0, 0,4'b0000, 1, 0,0,      0,0,1);
    // back-to-back 1111 then 0001
    add(1,0,1, B,4'b1111, 1, 0,0,      0,0,1);
    add(1,0,1, C,4'b0001, 1, 1,B+0,    0,0,0);
    add(1,0,1, C,4'b0001, 1, 1,B+1,    1,0,0);
    add(1,0,1, C,4'b0001, 1, 1,B+2,    2,0,0);
    add(1,0,1, C,4'b0001, 1, 1,B+3,    3,1,1);
    add(1,0,0, 0,4'b0000, 1, 1,C+0,    0,1,1);
    add(1,0,0, 0,4'b0000, 1, 0,0,      0,0,1);
    // backpressure over 0110
    add(1,0,1, D,4'b0110, 1, 0,0,      0,0,1);
    add(1,0,0, 0,4'b0000, 1, 1,D+1,    1,0,0);
    add(1,0,0, 0,4'b0000, 0, 1,D+2,    2,1,0);
    add(1,0,0, 0,4'b0000, 0, 1,D+2,    2,1,0);
    add(1,0,0, 0,4'b0000, 1, 1,D+2,    2,1,1);
    add(1,0,0, 0,4'b0000, 0, 0,0,      0,0,1);
    // empty mask then lane 3 only
    add(1,0,1, E,4'b0000, 1, 0,0,      0,0,1);
    add(1,0,1, E,4'b1000, 1, 0,0,      0,0,1);
    add(1,0,0, 0,4'b0000, 1, 1,E+3,    3,1,1);
    add(1,0,0, 0,4'b0000, 0, 0,0,      0,0,1);
    // flush after first item
    add(1,0,1, F,4'b1111, 1, 0,0,      0,0,1);
    add(1,0,0, 0,4'b0000, 1, 1,F+0,    0,0,0);
    add(1,1,1, G,4'b1111, 0, 1,F+1,    1,0,0);
    add(1,0,0, 0,4'b0000, 1, 0,0,      0,0,1);
    add(1,0,0, 0,4'b0000, 1, 0,0,      0,0,1);
    // reset mid-bundle with valid_in held
    add(1,0,1, H,4'b1111, 1, 0,0,      0,0,1);
    add(1,0,1, H,4'b1111, 1, 1,H+0,    0,0,0);
    add(0,0,1, H,4'b1111, 1, 1,H+1,    1,0,0);
    add(1,0,1, H,4'b1111, 1, 0,0,      0,0,1);
    add(1,0,0, 0,4'b0000, 1, 1,H+0,    0,0,0);

    foreach (tv[i]) begin
      drive(tv[i].rstn, tv[i].fl, tv[i].vin,
            tv[i].din, tv[i].mask, tv[i].rdy);
      chk($sformatf("v%0d valid_out", i), 32'(valid_out), 32'(tv[i].vout));
      chk($sformatf("v%0d data_out", i),  data_out,        tv[i].dout);
      chk($sformatf("v%0d lane_out", i),  32'(lane_out),  32'(tv[i].lane));
      chk($sformatf("v%0d last_out", i),  32'(last_out),  32'(tv[i].last));
      chk($sformatf("v%0d ready_in", i),  32'(ready_in),  32'(tv[i].rin));
    end

    // drain leftovers of the post-reset bundle
    budget = 0;
    while (valid_out && budget < 10) begin
      drive(1,0,0, '0,4'b0000, 1);
      budget++;
    end
    chk("drain idle", 32'(valid_out), 32'd0);

    // long stall: outputs frozen, no new bundle admitted
    drive(1,0,1, mk(G),4'b1111, 0);
    chk("stall accept", 32'(ready_in), 32'd1);
    for (int s = 0; s < 3; s++) begin
      drive(1,0,1, mk(A),4'b1111, 0);
      chk($sformatf("stall%0d data", s), data_out, G);
      chk($sformatf("stall%0d lane", s), 32'(lane_out), 32'd0);
      chk($sformatf("stall%0d ready_in", s), 32'(ready_in), 32'd0);
    end

    // release: four items, lanes 0..3, last only on lane 3
    n_items = 0;
    budget  = 0;
    drive(1,0,0, '0,4'b0000, 1);
    while (valid_out && budget < 10) begin
      chk($sformatf("rel%0d lane", n_items), 32'(lane_out), 32'(n_items));
      chk($sformatf("rel%0d data", n_items), data_out, G + 32'(n_items));
      chk($sformatf("rel%0d last", n_items), 32'(last_out),
          32'(n_items == 3));
      n_items++;
      budget++;
      drive(1,0,0, '0,4'b0000, 1);
    end
    chk("release budget", 32'(budget < 10), 32'd1);
    chk("release count", 32'(n_items), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bundle_unpack.md
# bundle_unpack

Serializes a registered bundle of up to N items, received on a valid/ready input, into one item per cycle on a valid/ready output. Lanes are emitted in ascending lane order and only lanes whose mask bit is set are emitted. It sits between wide producers (fetch packets, commit groups) and single-issue consumers in the out-of-order core. It is the narrowing counterpart of the single-item pipe stages used elsewhere in the design.

## Interface
- `data_t`, default `logic [31:0]`: item type.
- `N`, default 4: lanes per bundle; N ≥ 2.
- `IW`, default `$clog2(N)`: lane index width; derived, not overridden.

Ports:
- `clk`  in  1: clock.
- `resetn`  in  1: reset, synchronous, active-low.
- `flush`  in  1: synchronous discard of the held bundle.
- `ready_in`  out  1: block accepts a bundle this cycle.
- `valid_in`  in  1: bundle offered.
- `data_in`  in  N×data_t: bundle lanes; lane 0 is the oldest.
- `mask_in`  in  N: lane-valid bits.
- `ready_out`  in  1: consumer takes an item.
- `valid_out`  out  1: item offered.
- `data_out`  out  data_t: item.
- `lane_out`  out  IW: source lane of the item.
- `last_out`  out  1: item is the final pending lane of its bundle.

## Operation
- State:
  - `buf`: the held bundle, N×data_t.
  - `pend`: N bits, one per lane still to be emitted.
- `sel` = index of the lowest set bit of `pend`.
- Outputs (combinational from state):
  - `valid_out` = |pend.
  - `data_out` = buf[sel], or 0 when `pend` == 0.
  - `lane_out` = sel, or 0 when `pend` == 0.
  - `last_out` = valid_out && pend has exactly one bit set.
- `fire_out` = valid_out && ready_out.
  - On `fire_out`, pend[sel] is cleared at the next edge.
- `ready_in` = resetn && !flush && (pend == 0 || (fire_out && last_out)).
  - This gives back-to-back bundles with no bubble.
- `fire_in` = ready_in && valid_in.
  - On `fire_in`: buf ← data_in and pend ← mask_in. This overrides the clear from `fire_out` in the same cycle.
- An all-zero `mask_in` bundle is accepted and produces no item. `ready_in` stays high the next cycle.
- `flush` (while resetn is high):
  - pend ← 0 at the edge; buf is unchanged.
  - No input is accepted that cycle.
  - Any `fire_out` in the flush cycle still counts as delivered to the consumer.
- `data_in` is sampled only on `fire_in`. Lanes with mask 0 are stored but never emitted.

## Timing
- Reset: resetn low at an edge gives pend = 0 and buf = 0.
  - Thereafter valid_out = 0, data_out = 0, lane_out = 0, last_out = 0.
  - ready_in = 0 while resetn is low and 1 on the first cycle after.
- Latency: a bundle accepted at edge t presents its first item in cycle t+1.
- Throughput: one item per cycle while ready_out is held high. A bundle with k set lanes occupies exactly k output cycles.
- Stall: with ready_out low, all outputs hold stable and ready_in stays 0 whenever pend ≠ 0.
- Simultaneous last-item handshake and new bundle: the new bundle's first item appears in the next cycle. No idle cycle.
- Reset mid-bundle: pending items are lost. No item is emitted after reset.
- Priority at an edge: reset > flush > fire_in > fire_out clear.

## Structure
- Sub-module `prio_enc_low #(N)`, purely combinational.
  - Input: an N-bit vector.
  - Outputs: IW-bit index of the lowest set bit, `any`, and `one_hot` (exactly one bit set).
  - Reused for `sel` and `last_out`.
- No package types are required. `data_t` is a type parameter.
- If a shared util package exists, the lowest-set-bit helper function goes there. `prio_enc_low` wraps it.

## Test plan
- Reset, then bundle {A0,A1,A2,A3} with mask 4'b1011 and ready_out held high:
  - Outputs A0/lane0, A1/lane1, A3/lane3 on consecutive cycles.
  - last_out only on A3.
  - ready_in rises in the cycle A3 is handshaken.
- Back-to-back bundles: mask 4'b1111 then 4'b0001 (item B0), ready_out high:
  - Five consecutive valid cycles with no bubble.
  - last_out on lane3 of the first bundle and on B0.
- Backpressure: ready_out toggled 1,0,0,1,… over mask 4'b0110:
  - Items hold stable across stall cycles.
  - Exactly 2 handshakes; ready_in stays 0 until the second.
- All-zero mask bundle followed by mask 4'b1000:
  - The first bundle produces no valid_out.
  - The second yields lane_out=3 with last_out=1 two cycles after the first accept.
- Flush after the first item of mask 4'b1111:
  - valid_out = 0 in the next cycle.
  - ready_in = 0 during the flush cycle and 1 after.
  - No stale lanes reappear.
- Reset asserted mid-bundle with valid_in held high:
  - ready_in = 0 during reset.
  - All outputs are 0 after reset.
  - The bundle is accepted on the first cycle after reset.
